mips_multicycle: RTL and testbench
==================================

MIPS_MULTICYCLE -- requirements
Module: mips_multicycle

Interface
REQ-001 Parameter TEXT_BASE, default 32'h0000_4000, byte offset added to PC to form instruction fetch address.
REQ-002 Parameter DATA_BASE, default 32'h0000_0000, byte offset added to ALU result to form load/store address.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rstb  input  1  reset; synchronous, active-low.
REQ-006 mem_rd_data  input  32  combinational read data for the current mem_addr (instruction or data).
REQ-007 mem_addr  output  32  shared instruction/data memory address.
REQ-008 mem_wr_data  output  32  store data.
REQ-009 mem_wr_ena  output  1  store strobe, registered.
REQ-010 PC  output  32  program counter, registered.

Function
REQ-011 Multicycle FSM states: FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB; one state per cycle.
REQ-012 FETCH: mem_addr = TEXT_BASE + PC; IR <= mem_rd_data; PC <= PC + 4; next DECODE.
REQ-013 DECODE: A <= reg[IR[25:21]], B <= reg[IR[20:16]]; beq and j complete here (PC update) and return to FETCH; all others go to EXEC.
REQ-014 Branch target = PC + (sign-extended IR[15:0] << 2), where PC is already incremented; beq taken only if A == B, compared using current register values.
REQ-015 Jump target = {PC[31:28], IR[25:0], 2'b00}.
REQ-016 Supported: R-type funct add 0x20, sub 0x22, and 0x24, or 0x25, nor 0x27, slt 0x2A (signed); opcodes lw 0x23, sw 0x2B, addi 0x08, beq 0x04, j 0x02.
REQ-017 EXEC: ALUOut <= result; lw -> MEM_RD, sw -> MEM_WR, R-type/addi -> WB.
REQ-018 Arithmetic: 32-bit wrap-around, overflow ignored (no trap); immediates sign-extended for addi/lw/sw.
REQ-019 MEM_RD: mem_addr = DATA_BASE + ALUOut; MDR <= mem_rd_data; next WB.
REQ-020 MEM_WR: mem_addr = DATA_BASE + ALUOut; mem_wr_data = B; mem_wr_ena high for exactly this one cycle; next FETCH.
REQ-021 WB: write rd (R-type), rt (addi, lw) with ALUOut or MDR; next FETCH.
REQ-022 Register file 32 x 32; register 0 reads 0 always, writes to it discarded.
REQ-023 Cycle counts: beq/j 2, R-type/addi 4, sw 4, lw 5 (FETCH included).
REQ-024 Unknown opcode or funct: treated as NOP, DECODE -> FETCH, no register or memory write.
REQ-025 Outside MEM_WR, mem_wr_data = 0 and mem_wr_ena = 0.
REQ-026 Read-after-write across instructions is naturally safe; no forwarding logic required.

Reset
REQ-027 rstb low at a rising edge, in any state: state <= FETCH, PC <= RESET_PC, mem_wr_ena <= 0, IR/A/B/ALUOut/MDR <= 0, all registers <= 0.
REQ-028 Reset during MEM_WR suppresses the pending store from the following cycle onward; reset during WB discards the pending write.
REQ-029 First fetch occurs in the first cycle with rstb high, at TEXT_BASE + RESET_PC.

Configuration
REQ-030 Macro MIPS_IMM_LOGIC_EN defined: andi 0x0C, ori 0x0D (zero-extended imm), lui 0x0F (imm << 16) supported, 4 cycles, write rt.
REQ-031 Macro undefined: opcodes 0x0C/0x0D/0x0F decode as unknown per REQ-024.

Verification
REQ-032 Reset then release: mem_addr = 32'h4000 in cycle 1; PC = 4 after first fetch; mem_wr_ena stays 0.
REQ-033 addi r1,r0,5; addi r2,r0,7; add r3,r1,r2; sw r3,0x10(r0) -> store at addr 0x10 with data 12, mem_wr_ena high for one cycle.
REQ-034 lw r4,0x10(r0) with memory 0xDEADBEEF -> r4 = 0xDEADBEEF, observed by later sw; instruction takes 5 cycles.
REQ-035 beq r1,r1,-1 at PC 0x20 -> PC returns to 0x20 every 2 cycles; beq r1,r2 (unequal) -> PC = 0x24.
REQ-036 addi r0,r0,9 then sw r0 -> stored data 0; sub 0x8000_0000 - 1 -> 0x7FFF_FFFF, no trap.
REQ-037 Assert rstb low during MEM_WR of sw -> no further store, PC = RESET_PC; opcode 0x0D with/without MIPS_IMM_LOGIC_EN -> rt updated / unchanged.

Source files
------------

// File: rtl/mips_multicycle.sv
// Multicycle MIPS subset core: one FSM state per cycle, shared instruction/data memory port.
// Optional andi/ori/lui support is enabled by defining MIPS_IMM_LOGIC_EN.
//   state  | meaning
//   FETCH  | read instruction at TEXT_BASE+PC, PC += 4
//   DECODE | read operands; beq/j resolve here
//   EXEC   | ALU operation into alu_out
//   MEM_RD | load data into mdr
//   MEM_WR | store B at DATA_BASE+alu_out
//   WB     | register file write
module mips_multicycle #(
    parameter logic [31:0] TEXT_BASE = 32'h0000_4000,
    parameter logic [31:0] DATA_BASE = 32'h0000_0000,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic [31:0] mem_rd_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr_ena,
    output logic [31:0] PC
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB} state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    state_t      state;
    logic [31:0] ir, a_reg, b_reg, alu_out, mdr;
    logic [31:0] regs [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, wb_idx;
    logic [31:0] sext, rs_val, rt_val, alu_res, wb_val;
    logic        is_rtype, is_imm_logic, exec_ok;

    assign opcode = ir[31:26];
    assign funct  = ir[5:0];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign sext   = {{16{ir[15]}}, ir[15:0]};
    assign rs_val = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rt_val = (rt == 5'd0) ? 32'd0 : regs[rt];

    assign is_rtype = (opcode == OP_R) && (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                                           funct == 6'h25 || funct == 6'h27 || funct == 6'h2A);
`ifdef MIPS_IMM_LOGIC_EN
    assign is_imm_logic = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_LUI);
`else
    assign is_imm_logic = 1'b0;
`endif
    assign exec_ok = is_rtype || is_imm_logic || opcode == OP_ADDI || opcode == OP_LW || opcode == OP_SW;

    always_comb begin
        alu_res = a_reg + sext;
        if (opcode == OP_R) begin
            case (funct)
                6'h22:   alu_res = a_reg - b_reg;
                6'h24:   alu_res = a_reg & b_reg;
                6'h25:   alu_res = a_reg | b_reg;
                6'h27:   alu_res = ~(a_reg | b_reg);
                6'h2A:   alu_res = {31'd0, $signed(a_reg) < $signed(b_reg)};
                default: alu_res = a_reg + b_reg;
            endcase
        end
`ifdef MIPS_IMM_LOGIC_EN
        else if (opcode == OP_ANDI) alu_res = a_reg & {16'd0, ir[15:0]};
        else if (opcode == OP_ORI)  alu_res = a_reg | {16'd0, ir[15:0]};
        else if (opcode == OP_LUI)  alu_res = {ir[15:0], 16'd0};
`endif
    end

    assign wb_idx      = (opcode == OP_R) ? rd : rt;
    assign wb_val      = (opcode == OP_LW) ? mdr : alu_out;
    assign mem_addr    = (state == MEM_RD || state == MEM_WR) ? DATA_BASE + alu_out : TEXT_BASE + PC;
    assign mem_wr_data = (state == MEM_WR) ? b_reg : 32'd0;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state      <= FETCH;
            PC         <= RESET_PC;
            mem_wr_ena <= 1'b0;
            ir         <= 32'd0;
            a_reg      <= 32'd0;
            b_reg      <= 32'd0;
            alu_out    <= 32'd0;
            mdr        <= 32'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else begin
            mem_wr_ena <= 1'b0;
            case (state)
                FETCH: begin
                    ir    <= mem_rd_data;
                    PC    <= PC + 32'd4;
                    state <= DECODE;
                end
                DECODE: begin
                    a_reg <= rs_val;
                    b_reg <= rt_val;
                    if (opcode == OP_BEQ) begin
                        if (rs_val == rt_val) PC <= PC + (sext << 2);
                        state <= FETCH;
                    end else if (opcode == OP_J) begin
                        PC    <= {PC[31:28], ir[25:0], 2'b00};
                        state <= FETCH;
                    end else begin
                        state <= exec_ok ? EXEC : FETCH;
                    end
                end
                EXEC: begin
                    alu_out <= alu_res;
                    if (opcode == OP_LW) begin
                        state <= MEM_RD;
                    end else if (opcode == OP_SW) begin
                        state      <= MEM_WR;
                        mem_wr_ena <= 1'b1;
                    end else begin
                        state <= WB;
                    end
                end
                MEM_RD: begin
                    mdr   <= mem_rd_data;
                    state <= WB;
                end
                MEM_WR: state <= FETCH;
                WB: begin
                    if (wb_idx != 5'd0) regs[wb_idx] <= wb_val;
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: ALU vector table plus hand-written program sequences.
module tb_mips_multicycle;
    logic        clk, rstb;
    logic [31:0] mem_rd_data, mem_addr, mem_wr_data, PC;
    logic        mem_wr_ena;

    logic [31:0] mem [8192];
    int          cyc, st_cnt, st_cyc, n_checks, n_fail;
    logic [31:0] st_addr, st_data;

    mips_multicycle dut (
        .clk(clk), .rstb(rstb), .mem_rd_data(mem_rd_data), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_ena(mem_wr_ena), .PC(PC)
    );

    assign mem_rd_data = mem[mem_addr[14:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle k is observed at the k-th falling edge after reset release.
    always @(negedge clk) begin
        if (rstb) cyc = cyc + 1;
        if (mem_wr_ena) begin
            st_cnt  = st_cnt + 1;
            st_addr = mem_addr;
            st_data = mem_wr_data;
            st_cyc  = cyc;
            mem[mem_addr[14:2]] = mem_wr_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_r(logic [5:0] fn, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction
    function automatic logic [31:0] enc_j(logic [25:0] tgt);
        return {6'h02, tgt};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 8192; i++) mem[i] = 32'd0;
    endtask

    task automatic put(logic [31:0] pc, logic [31:0] instr);
        logic [31:0] a;
        a = 32'h4000 + pc;
        mem[a[14:2]] = instr;
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset(string name);
        rstb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check({name, "_rst_pc"}, PC, 32'd0);
        check({name, "_rst_wena"}, {31'd0, mem_wr_ena}, 32'd0);
        cyc = 0;
        st_cnt = 0;
        st_cyc = 0;
        st_addr = 32'd0;
        st_data = 32'd0;
        rstb = 1'b1;
    endtask

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          exp_cyc;
    } alu_vec_t;

    alu_vec_t vecs [10];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        st_cnt   = 0;
        rstb     = 1'b0;

        vecs[0] = '{6'h20, 32'd5,          32'd7,          32'd12,         18};
        vecs[1] = '{6'h20, 32'hFFFF_FFFF,  32'd1,          32'd0,          18};
        vecs[2] = '{6'h22, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  18};
        vecs[3] = '{6'h24, 32'hF0F0_1234,  32'h0FF0_FFFF,  32'h00F0_1234,  18};
        vecs[4] = '{6'h25, 32'h0000_00F0,  32'h0F00_000F,  32'h0F00_00FF,  18};
        vecs[5] = '{6'h27, 32'h0000_FFFF,  32'h00FF_0000,  32'hFF00_0000,  18};
        vecs[6] = '{6'h2A, 32'hFFFF_FFFF,  32'd1,          32'd1,          18};
        vecs[7] = '{6'h2A, 32'd1,          32'hFFFF_FFFF,  32'd0,          18};
        vecs[8] = '{6'h2A, 32'h8000_0000,  32'h7FFF_FFFF,  32'd1,          18};
        vecs[9] = '{6'h21, 32'd5,          32'd7,          32'd0,          16};

        // Reset release, first fetch, and addi/addi/add/sw.
        clear_mem();
        put(32'h00, enc_i(6'h08, 0, 1, 16'd5));
        put(32'h04, enc_i(6'h08, 0, 2, 16'd7));
        put(32'h08, enc_r(6'h20, 1, 2, 3));
        put(32'h0C, enc_i(6'h2B, 0, 3, 16'h0010));
        put(32'h10, enc_i(6'h04, 0, 0, 16'hFFFF));
        do_reset("boot");
        step(1);
        check("boot_fetch_addr", mem_addr, 32'h4000);
        check("boot_wena_c1", {31'd0, mem_wr_ena}, 32'd0);
        step(1);
        check("boot_pc_c2", PC, 32'd4);
        step(28);
        check("add_st_cnt", st_cnt, 1);
        check("add_st_addr", st_addr, 32'h10);
        check("add_st_data", st_data, 32'd12);
        check("add_st_cyc", st_cyc, 16);

        // ALU table: lw r1; lw r2; R-op r3; sw r3.
        foreach (vecs[k]) begin
            clear_mem();
            mem[0] = vecs[k].a;
            mem[1] = vecs[k].b;
            put(32'h00, enc_i(6'h23, 0, 1, 16'h0000));
            put(32'h04, enc_i(6'h23, 0, 2, 16'h0004));
            put(32'h08, enc_r(vecs[k].funct, 1, 2, 3));
            put(32'h0C, enc_i(6'h2B, 0, 3, 16'h0010));
            put(32'h10, enc_i(6'h04, 0, 0, 16'hFFFF));
            do_reset($sformatf("vec%0d", k));
            step(30);
            check($sformatf("vec%0d_st_cnt", k), st_cnt, 1);
            check($sformatf("vec%0d_st_addr", k), st_addr, 32'h10);
            check($sformatf("vec%0d_st_data", k), st_data, vecs[k].exp);
            check($sformatf("vec%0d_st_cyc", k), st_cyc, vecs[k].exp_cyc);
        end

        // lw takes 5 cycles and its result feeds a later sw.
        clear_mem();
        mem[4] = 32'hDEAD_BEEF;
        put(32'h00, enc_i(6'h23, 0, 4, 16'h0010));
        put(32'h04, enc_i(6'h2B, 0, 4, 16'h0020));
        put(32'h08, enc_i(6'h04, 0, 0, 16'hFFFF));
        do_reset("lw");
        step(4);
        check("lw_memrd_addr", mem_addr, 32'h10);
        step(16);
        check("lw_st_data", st_data, 32'hDEAD_BEEF);
        check("lw_st_addr", st_addr, 32'h20);
        check("lw_st_cyc", st_cyc, 9);

        // j to 0x20, then beq r1,r1,-1 spins every 2 cycles.
        clear_mem();
        put(32'h00, enc_j(26'd8));
        put(32'h20, enc_i(6'h04, 1, 1, 16'hFFFF));
        do_reset("beq_eq");
        step(5);
        check("beq_eq_pc_c5", PC, 32'h20);
        check("beq_eq_addr_c5", mem_addr, 32'h4020);
        step(1);
        check("beq_eq_pc_c6", PC, 32'h24);
        step(1);
        check("beq_eq_pc_c7", PC, 32'h20);
        step(2);
        check("beq_eq_pc_c9", PC, 32'h20);

        // Unequal beq falls through to 0x24.
        clear_mem();
        put(32'h00, enc_i(6'h08, 0, 1, 16'd1));
        put(32'h04, enc_j(26'd8));
        put(32'h20, enc_i(6'h04, 1, 2, 16'hFFFF));
        put(32'h24, enc_i(6'h2B, 0, 1, 16'h0030));
        put(32'h28, enc_i(6'h04, 0, 0, 16'hFFFF));
        do_reset("beq_ne");
        step(9);
        check("beq_ne_pc_c9", PC, 32'h24);
        step(11);
        check("beq_ne_st_cyc", st_cyc, 12);
        check("beq_ne_st_data", st_data, 32'd1);
        check("beq_ne_st_addr", st_addr, 32'h30);

        // Writes to r0 are discarded.
        clear_mem();
        mem[4] = 32'h0000_0055;
        put(32'h00, enc_i(6'h08, 0, 0, 16'd9));
        put(32'h04, enc_i(6'h2B, 0, 0, 16'h0010));
        put(32'h08, enc_i(6'h04, 0, 0, 16'hFFFF));
        do_reset("r0");
        step(20);
        check("r0_st_cyc", st_cyc, 8);
        check("r0_st_data", st_data, 32'd0);
        check("r0_mem", mem[4], 32'd0);

        // Reset asserted during MEM_WR of the first sw: no later store.
        clear_mem();
        put(32'h00, enc_i(6'h08, 0, 1, 16'd5));
        put(32'h04, enc_i(6'h2B, 0, 1, 16'h0010));
        put(32'h08, enc_i(6'h2B, 0, 1, 16'h0014));
        do_reset("rst_wr");
        step(8);
        check("rst_wr_wena_c8", {31'd0, mem_wr_ena}, 32'd1);
        check("rst_wr_addr_c8", mem_addr, 32'h10);
        rstb = 1'b0;
        step(1);
        check("rst_wr_wena_after", {31'd0, mem_wr_ena}, 32'd0);
        check("rst_wr_pc_after", PC, 32'd0);
        step(3);
        check("rst_wr_st_cnt", st_cnt, 1);
        check("rst_wr_mem14", mem[5], 32'd0);

        // ori r5,r0,0xF0 then sw r5: depends on the immediate-logic build option.
        clear_mem();
        put(32'h00, enc_i(6'h0D, 0, 5, 16'h00F0));
        put(32'h04, enc_i(6'h2B, 0, 5, 16'h0010));
        put(32'h08, enc_i(6'h04, 0, 0, 16'hFFFF));
        do_reset("ori");
        step(20);
`ifdef MIPS_IMM_LOGIC_EN
        check("ori_st_data", st_data, 32'h0000_00F0);
        check("ori_st_cyc", st_cyc, 8);
`else
        check("ori_st_data", st_data, 32'd0);
        check("ori_st_cyc", st_cyc, 6);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
